uart_tx_arbiter: RTL and testbench

Shares the single UART transmit path of the board-level SoC between two byte-stream requesters, e.g. the CPU UART peripheral and a debug/boot-message source. It grants the transmitter to one requester per message (a burst of bytes ending in `last`), alternates round-robin between messages, and reclaims a grant that stalls for too long. It sits between the requesters and the UART serializer's valid/ready byte input.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a UART serializer byte input.
// Grants one whole message at a time, alternates between messages, and revokes stalled grants.
module uart_tx_arbiter #(
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] req0_data,
   input  logic       req0_valid,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic [7:0] req1_data,
   input  logic       req1_valid,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [1:0] grant,
   output logic       timeout_pulse
);

   localparam bit          TO_EN   = (LOCK_TIMEOUT_CYCLES != 0);
   localparam int unsigned CW      = TO_EN ? $clog2(LOCK_TIMEOUT_CYCLES + 1) : 1;
   localparam int unsigned TO_LAST = TO_EN ? LOCK_TIMEOUT_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic           last_served_q, last_served_d;
   logic [CW-1:0]  idle_cnt_q, idle_cnt_d;
   logic           pulse_q, pulse_d;

   logic           granted;
   logic           g_idx;
   logic           g_valid;
   logic           g_last;
   logic           xfer;
   logic           idle_tick;
   logic           to_hit;

   // Current owner's handshake view, shared by both grant states.
   assign granted   = (state_q == GRANT0) || (state_q == GRANT1);
   assign g_idx     = (state_q == GRANT1);
   assign g_valid   = g_idx ? req1_valid : req0_valid;
   assign g_last    = g_idx ? req1_last  : req0_last;
   assign xfer      = granted && g_valid && tx_ready;
   assign idle_tick = granted && !g_valid;
   assign to_hit    = TO_EN && idle_tick && (idle_cnt_q == CW'(TO_LAST));

   assign timeout_pulse = pulse_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         last_served_q <= 1'b1;
         idle_cnt_q    <= '0;
         pulse_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         idle_cnt_q    <= idle_cnt_d;
         pulse_q       <= pulse_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      idle_cnt_d    = idle_cnt_q;
      pulse_d       = 1'b0;
      tx_data       = '0;
      tx_valid      = 1'b0;
      req0_ready    = 1'b0;
      req1_ready    = 1'b0;
      grant         = 2'b00;

      unique case (state_q)
         IDLE: begin
            idle_cnt_d = '0;
            if (req0_valid && req1_valid) begin
               state_d = last_served_q ? GRANT0 : GRANT1;
            end else if (req0_valid) begin
               state_d = GRANT0;
            end else if (req1_valid) begin
               state_d = GRANT1;
            end
         end
         GRANT0: begin
            tx_data    = req0_data;
            tx_valid   = req0_valid;
            req0_ready = tx_ready;
            grant      = 2'b01;
         end
         GRANT1: begin
            tx_data    = req1_data;
            tx_valid   = req1_valid;
            req1_ready = tx_ready;
            grant      = 2'b10;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A transfer always beats the timeout; backpressured cycles neither count nor clear.
      if (granted) begin
         if (xfer) begin
            idle_cnt_d = '0;
            if (g_last) begin
               state_d       = IDLE;
               last_served_d = g_idx;
            end
         end else if (to_hit) begin
            state_d       = IDLE;
            last_served_d = g_idx;
            pulse_d       = 1'b1;
            idle_cnt_d    = '0;
         end else if (idle_tick && (idle_cnt_q != '1)) begin
            idle_cnt_d = idle_cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a message-level model checks two instances
// (timeout 16 and timeout disabled) every cycle, plus literal checks of key scenarios.
module tb_uart_tx_arbiter;

   localparam int unsigned LIM_A = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] d0 = '0, d1 = '0;
   logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0, txr = 1'b0;

   logic [7:0] tx_data_a, tx_data_z;
   logic       tx_valid_a, tx_valid_z, rdy0_a, rdy0_z, rdy1_a, rdy1_z;
   logic [1:0] grant_a, grant_z;
   logic       pulse_a, pulse_z;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_arbiter #(.LOCK_TIMEOUT_CYCLES(LIM_A)) dut (
      .clock(clk), .reset_n(rst_n),
      .req0_data(d0), .req0_valid(v0), .req0_last(l0), .req0_ready(rdy0_a),
      .req1_data(d1), .req1_valid(v1), .req1_last(l1), .req1_ready(rdy1_a),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(txr),
      .grant(grant_a), .timeout_pulse(pulse_a)
   );

   uart_tx_arbiter #(.LOCK_TIMEOUT_CYCLES(0)) dz (
      .clock(clk), .reset_n(rst_n),
      .req0_data(d0), .req0_valid(v0), .req0_last(l0), .req0_ready(rdy0_z),
      .req1_data(d1), .req1_valid(v1), .req1_last(l1), .req1_ready(rdy1_z),
      .tx_data(tx_data_z), .tx_valid(tx_valid_z), .tx_ready(txr),
      .grant(grant_z), .timeout_pulse(pulse_z)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Message-level model: owner (-1 = nobody), who was served last, and run of idle granted cycles.
   int owner [2] = '{-1, -1};
   int lsrv  [2] = '{1, 1};
   int run   [2] = '{0, 0};
   bit pls   [2] = '{1'b0, 1'b0};
   int lim   [2] = '{int'(LIM_A), 0};
   int t_o, t_ls, t_r;
   bit t_p;
   logic t_v, t_l;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            owner[k] <= -1; lsrv[k] <= 1; run[k] <= 0; pls[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            t_o = owner[k]; t_ls = lsrv[k]; t_r = run[k]; t_p = 1'b0;
            if (t_o < 0) begin
               if (v0 && v1) t_o = 1 - t_ls;
               else if (v0)  t_o = 0;
               else if (v1)  t_o = 1;
               t_r = 0;
            end else begin
               t_v = (t_o == 1) ? v1 : v0;
               t_l = (t_o == 1) ? l1 : l0;
               if (t_v && txr) begin
                  t_r = 0;
                  if (t_l) begin t_ls = t_o; t_o = -1; end
               end else if (!t_v) begin
                  t_r++;
                  if (lim[k] != 0 && t_r == lim[k]) begin
                     t_ls = t_o; t_o = -1; t_p = 1'b1; t_r = 0;
                  end
               end
            end
            owner[k] <= t_o; lsrv[k] <= t_ls; run[k] <= t_r; pls[k] <= t_p;
         end
      end
   end

   logic [7:0] e_d;
   logic       e_v, e_r0, e_r1;
   logic [1:0] e_g;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         e_d = '0; e_v = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0; e_g = 2'b00;
         if (owner[k] == 0) begin
            e_d = d0; e_v = v0; e_r0 = txr; e_g = 2'b01;
         end else if (owner[k] == 1) begin
            e_d = d1; e_v = v1; e_r1 = txr; e_g = 2'b10;
         end
         if (k == 0) begin
            chk("a.tx_data", 32'(tx_data_a), 32'(e_d));
            chk("a.tx_valid", 32'(tx_valid_a), 32'(e_v));
            chk("a.req0_ready", 32'(rdy0_a), 32'(e_r0));
            chk("a.req1_ready", 32'(rdy1_a), 32'(e_r1));
            chk("a.grant", 32'(grant_a), 32'(e_g));
            chk("a.timeout_pulse", 32'(pulse_a), 32'(pls[k]));
         end else begin
            chk("z.tx_data", 32'(tx_data_z), 32'(e_d));
            chk("z.tx_valid", 32'(tx_valid_z), 32'(e_v));
            chk("z.req0_ready", 32'(rdy0_z), 32'(e_r0));
            chk("z.req1_ready", 32'(rdy1_z), 32'(e_r1));
            chk("z.grant", 32'(grant_z), 32'(e_g));
            chk("z.timeout_pulse", 32'(pulse_z), 32'(pls[k]));
         end
      end
   end

   // Accepted-byte log and timeout pulses of the 16-cycle instance.
   int         lc[$];
   logic [7:0] ld[$];
   logic [1:0] lg[$];
   int         pa[$];
   int         pz = 0;

   always @(negedge clk) begin
      if (tx_valid_a && txr) begin
         lc.push_back(cyc); ld.push_back(tx_data_a); lg.push_back(grant_a);
      end
      if (pulse_a) pa.push_back(cyc);
      if (pulse_z) pz++;
   end

   task automatic chk_log(input int i, input int c, input logic [7:0] d, input logic [1:0] g);
      if (i < lc.size()) begin
         chk("log.cycle", 32'(lc[i]), 32'(c));
         chk("log.data", 32'(ld[i]), 32'(d));
         chk("log.grant", 32'(lg[i]), 32'(g));
      end else begin
         chk("log.length", 32'(lc.size()), 32'(i + 1));
      end
   endtask

   task automatic set_req(input int n, input logic v, input logic [7:0] d, input logic l);
      if (n == 0) begin v0 = v; d0 = d; l0 = l; end
      else        begin v1 = v; d1 = d; l1 = l; end
   endtask

   // Posts cnt bytes (lowest byte of 'bytes' first), holding each until the DUT accepts it.
   task automatic send(input int n, input logic [31:0] bytes, input int cnt,
                       input bit with_last, input int budget);
      bit hs;
      int w;
      for (int i = 0; i < cnt; i++) begin
         set_req(n, 1'b1, bytes[8*i +: 8], with_last && (i == cnt - 1));
         hs = 1'b0;
         w  = 0;
         while (!hs && w < budget) begin
            @(negedge clk);
            hs = (n == 0) ? (rdy0_a && v0) : (rdy1_a && v1);
            @(posedge clk); #1;
            w++;
         end
         if (!hs) chk("send.accept_wait", 32'(w), 32'(budget + 1));
      end
      set_req(n, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_req(0, 1'b0, 8'h00, 1'b0);
      set_req(1, 1'b0, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      lc.delete(); ld.delete(); lg.delete(); pa.delete(); pz = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   int c;

   initial begin
      // Reset state.
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("reset.grant", 32'(grant_a), 32'h0);
      chk("reset.tx_valid", 32'(tx_valid_a), 32'h0);
      chk("reset.pulse", 32'(pulse_a), 32'h0);
      do_reset();

      // Single 3-byte message from req0.
      txr = 1'b1;
      c = cyc;
      send(0, 32'h0043_4241, 3, 1'b1, 100);
      chk_log(0, c + 1, 8'h41, 2'b01);
      chk_log(1, c + 2, 8'h42, 2'b01);
      chk_log(2, c + 3, 8'h43, 2'b01);
      @(negedge clk);
      chk("msg1.grant_after", 32'(grant_a), 32'h0);

      // Two rounds of simultaneous 2-byte messages: strict alternation with one bubble.
      do_reset();
      txr = 1'b1;
      c = cyc;
      fork
         send(0, 32'h0000_ABAA, 2, 1'b1, 100);
         send(1, 32'h0000_BBBA, 2, 1'b1, 100);
      join
      fork
         send(0, 32'h0000_CBCA, 2, 1'b1, 100);
         send(1, 32'h0000_DBDA, 2, 1'b1, 100);
      join
      chk_log(0, c + 1, 8'hAA, 2'b01);
      chk_log(1, c + 2, 8'hAB, 2'b01);
      chk_log(2, c + 4, 8'hBA, 2'b10);
      chk_log(3, c + 5, 8'hBB, 2'b10);
      chk_log(4, c + 7, 8'hCA, 2'b01);
      chk_log(5, c + 8, 8'hCB, 2'b01);
      chk_log(6, c + 10, 8'hDA, 2'b10);
      chk_log(7, c + 11, 8'hDB, 2'b10);

      // Long serializer backpressure never times out.
      do_reset();
      txr = 1'b0;
      c = cyc;
      fork
         send(1, 32'h0000_005A, 1, 1'b1, 5000);
         begin
            repeat (2000) @(posedge clk);
            #1 txr = 1'b1;
         end
         begin
            repeat (1000) @(negedge clk);
            chk("stall.tx_data", 32'(tx_data_a), 32'h5A);
            chk("stall.tx_valid", 32'(tx_valid_a), 32'h1);
            chk("stall.grant", 32'(grant_a), 32'h2);
         end
      join
      chk_log(0, c + 2000, 8'h5A, 2'b10);
      chk("stall.pulses", 32'(pa.size()), 32'h0);

      // Idle grant revoked after 16 cycles; pending req1 served next.
      do_reset();
      txr = 1'b1;
      c = cyc;
      send(0, 32'h0000_0011, 1, 1'b0, 100);
      send(1, 32'h0000_0022, 1, 1'b1, 100);
      chk_log(0, c + 1, 8'h11, 2'b01);
      chk_log(1, c + 19, 8'h22, 2'b10);
      chk("timeout.pulse_count", 32'(pa.size()), 32'h1);
      if (pa.size() > 0) chk("timeout.pulse_cycle", 32'(pa[0]), 32'(c + 18));

      // Reset in the middle of a req1 message, then the first tie goes to req0.
      do_reset();
      txr = 1'b1;
      send(0, 32'h0000_0033, 1, 1'b1, 100);
      txr = 1'b0;
      set_req(1, 1'b1, 8'h44, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("midreset.grant_before", 32'(grant_a), 32'h2);
      chk("midreset.data_before", 32'(tx_data_a), 32'h44);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midreset.grant", 32'(grant_a), 32'h0);
      chk("midreset.tx_valid", 32'(tx_valid_a), 32'h0);
      chk("midreset.tx_data", 32'(tx_data_a), 32'h0);
      chk("midreset.req1_ready", 32'(rdy1_a), 32'h0);
      set_req(1, 1'b0, 8'h00, 1'b0);
      txr = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      lc.delete(); ld.delete(); lg.delete();
      c = cyc;
      fork
         send(0, 32'h0000_0055, 1, 1'b1, 100);
         send(1, 32'h0000_0066, 1, 1'b1, 100);
      join
      chk_log(0, c + 1, 8'h55, 2'b01);
      chk_log(1, c + 3, 8'h66, 2'b10);

      // Timeout disabled: a stalled grant is kept indefinitely.
      do_reset();
      txr = 1'b1;
      send(0, 32'h0000_0077, 1, 1'b0, 100);
      repeat (3000) @(posedge clk);
      @(negedge clk);
      chk("notimeout.grant", 32'(grant_z), 32'h1);
      chk("notimeout.pulses", 32'(pz), 32'h0);
      chk("limit16.pulses", 32'(pa.size()), 32'h1);
      chk("limit16.grant", 32'(grant_a), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
